rx_phase_align: RTL and testbench
=================================

RX_PHASE_ALIGN -- requirements
Module: rx_phase_align

Interface
REQ-001 The module SHALL have parameter NB_DATA, default 8, meaning width of the signed two's-complement input sample.
REQ-002 The module SHALL have parameter OS, default 4, meaning samples per symbol (oversampling factor, 2..16).
REQ-003 The module SHALL have parameter WIN_LOG2, default 6, meaning log2 of the symbols per energy window (64 symbols).
REQ-004 The module SHALL have parameter LOCK_WINS, default 2, meaning consecutive windows with an unchanged best phase required to declare lock.
REQ-005 The module SHALL have port clock, input, 1 bit: system clock; all logic is on its rising edge.
REQ-006 The module SHALL have port i_reset, input, 1 bit: reset, synchronous, active-high.
REQ-007 The module SHALL have port i_enable, input, 1 bit: when 0, all state holds and no output strobes are issued.
REQ-008 The module SHALL have port i_valid, input, 1 bit: qualifies i_data as one sample.
REQ-009 The module SHALL have port i_data, input, NB_DATA bits, signed: filter output sample.
REQ-010 The module SHALL have port i_mode, input, 1 bit: 0 = automatic phase search, 1 = manual phase.
REQ-011 The module SHALL have port i_manual_phase, input, clog2(OS) bits: sampling phase used in manual mode.
REQ-012 The module SHALL have port i_restart, input, 1 bit: one-cycle pulse that discards accumulated energy and restarts acquisition.
REQ-013 The module SHALL have port o_bit, output, 1 bit: decided bit, equal to the sign of the selected sample (negative = 1).
REQ-014 The module SHALL have port o_bit_valid, output, 1 bit: one-cycle strobe qualifying o_bit.
REQ-015 The module SHALL have port o_phase, output, clog2(OS) bits: phase currently used for decisions.
REQ-016 The module SHALL have port o_locked, output, 1 bit: phase selection is stable.

Function
REQ-017 A sample-phase counter SHALL advance 0..OS-1 on each cycle with i_valid=1 and i_enable=1, wrapping from OS-1 to 0; it SHALL hold otherwise.
REQ-018 Per phase p, accumulator E[p] SHALL add |i_data| when the counter equals p; |-2^(NB_DATA-1)| = 2^(NB_DATA-1) exactly; width NB_DATA+WIN_LOG2 unsigned, no saturation needed.
REQ-019 A symbol counter SHALL count counter wraps; window end is the wrap that completes 2^WIN_LOG2 symbols.
REQ-020 At window end, best = argmax E[p]; ties SHALL resolve to the lowest index; all E[p] SHALL clear so that the sample arriving in the window-end cycle starts the new window.
REQ-021 The FSM SHALL have states IDLE, ACQ, and TRACK: IDLE->ACQ on first enabled sample; ACQ->TRACK when best is unchanged for LOCK_WINS consecutive window ends; TRACK->ACQ when a window end yields a different best.
REQ-022 In auto mode, o_phase SHALL update to best at every window end (registered, visible the next cycle); o_locked = (state == TRACK).
REQ-023 In manual mode, o_phase SHALL equal i_manual_phase (registered, 1 cycle) and o_locked = 1; energy accumulation and the FSM SHALL continue so that a return to auto mode is seamless.
REQ-024 Decision: when i_valid=1, i_enable=1, and counter == o_phase, the next cycle SHALL have o_bit_valid=1 and o_bit = i_data[NB_DATA-1]; latency is exactly 1 clock; at most one strobe per symbol.
REQ-025 If o_phase changes mid-symbol, a symbol SHALL yield at most one strobe and may yield none; no duplicate strobe is permitted.
REQ-026 i_restart SHALL clear the counters, E[p], and the lock history, set state to ACQ, and force o_locked=0; o_phase SHALL hold its value; i_reset SHALL take priority over i_restart.
REQ-027 When i_enable=0, o_bit_valid SHALL be 0 and all registers SHALL hold.

Reset
REQ-028 While i_reset=1 at a clock edge, the next state SHALL be: o_bit=0, o_bit_valid=0, o_phase=0, o_locked=0, FSM=IDLE, all counters and E[p]=0.
REQ-029 Reset asserted mid-window SHALL discard the partial window entirely; no strobe SHALL be emitted in the cycle after reset deasserts.

Verification
REQ-030 The bench SHALL cover: OS=4, i_valid always high, input pattern {+10,+100,+20,+5} repeated (auto mode) -> o_phase=1 after window 1, o_locked=1 after window 2 (cycle 512), o_bit=0 on every strobe.
REQ-031 The bench SHALL cover: the same stream with phase 1 sample = -100 on alternate symbols -> o_bit alternates 1/0, and one strobe appears every 4 valid samples.
REQ-032 The bench SHALL cover: equal magnitudes on all phases -> o_phase=0 (tie rule), and o_locked=1 after 2 windows.
REQ-033 The bench SHALL cover: locked on phase 1, then the stream shifts to peak at phase 3 -> o_locked drops at the next window end, o_phase=3, and relock occurs one window later.
REQ-034 The bench SHALL cover: i_mode=1 with i_manual_phase=2 -> o_phase=2 and o_locked=1 one cycle later, decisions taken on phase 2 regardless of energy.
REQ-035 The bench SHALL cover: i_data=-128 (NB_DATA=8) on every sample -> no accumulator overflow (E = 128*64 = 8192 at window end), and o_bit=1.

Source files
------------

// File: rtl/rx_phase_align.sv
// Symbol-timing recovery by energy search: picks the oversampling phase with the
// largest |sample| energy per window and slices the sign of that phase into bits.
module rx_phase_align #(
  parameter int NB_DATA   = 8,
  parameter int OS        = 4,
  parameter int WIN_LOG2  = 6,
  parameter int LOCK_WINS = 2
) (
  input  logic                      clock,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic                      i_valid,
  input  logic signed [NB_DATA-1:0] i_data,
  input  logic                      i_mode,
  input  logic [$clog2(OS)-1:0]     i_manual_phase,
  input  logic                      i_restart,
  output logic                      o_bit,
  output logic                      o_bit_valid,
  output logic [$clog2(OS)-1:0]     o_phase,
  output logic                      o_locked
);

  localparam int PW = $clog2(OS);
  localparam int EW = NB_DATA + WIN_LOG2;
  localparam int SW = $clog2(LOCK_WINS + 1);

  typedef enum logic [1:0] {IDLE, ACQ, TRACK} state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         phase_cnt_q, phase_cnt_d;
  logic [WIN_LOG2-1:0]   sym_cnt_q, sym_cnt_d;
  logic [EW-1:0]         energy_q [OS];
  logic [EW-1:0]         energy_d [OS];
  logic                  have_hist_q, have_hist_d;
  logic [PW-1:0]         last_best_q, last_best_d;
  logic [SW-1:0]         stable_cnt_q, stable_cnt_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic                  locked_q, locked_d;
  logic                  bit_q, bit_d;
  logic                  bit_valid_q, bit_valid_d;
  logic                  strobe_done_q, strobe_done_d;

  logic                  smp, wrap, win_end, strobe, same_best;
  logic signed [NB_DATA:0] data_ext;
  logic [NB_DATA:0]      mag;
  logic [PW-1:0]         best;
  logic [EW-1:0]         best_e;

  // Strict '>' keeps the lowest index on ties.
  always_comb begin
    best   = '0;
    best_e = energy_q[0];
    for (int p = 1; p < OS; p++) begin
      if (energy_q[p] > best_e) begin
        best   = PW'(p);
        best_e = energy_q[p];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    phase_cnt_d   = phase_cnt_q;
    sym_cnt_d     = sym_cnt_q;
    energy_d      = energy_q;
    have_hist_d   = have_hist_q;
    last_best_d   = last_best_q;
    stable_cnt_d  = stable_cnt_q;
    phase_d       = phase_q;
    locked_d      = locked_q;
    bit_d         = bit_q;
    bit_valid_d   = 1'b0;
    strobe_done_d = strobe_done_q;

    data_ext  = {i_data[NB_DATA-1], i_data};
    mag       = data_ext[NB_DATA] ? -data_ext : data_ext;
    smp       = i_enable & i_valid;
    wrap      = smp && (phase_cnt_q == PW'(OS - 1));
    win_end   = wrap && (sym_cnt_q == '1);
    strobe    = smp && (phase_cnt_q == phase_q) && !strobe_done_q;
    same_best = have_hist_q && (best == last_best_q);

    if (smp) begin
      phase_cnt_d = wrap ? '0 : phase_cnt_q + PW'(1);
      if (wrap) sym_cnt_d = sym_cnt_q + WIN_LOG2'(1);
      // The sample of the window-end cycle already belongs to the next window.
      if (win_end) begin
        for (int p = 0; p < OS; p++) energy_d[p] = '0;
      end
      energy_d[phase_cnt_q] = energy_d[phase_cnt_q] + EW'(mag);
      if (strobe) begin
        bit_valid_d = 1'b1;
        bit_d       = i_data[NB_DATA-1];
      end
      strobe_done_d = wrap ? 1'b0 : (strobe_done_q | strobe);
      if (state_q == IDLE) state_d = ACQ;
      if (win_end) begin
        stable_cnt_d = !same_best ? SW'(1) :
                       (stable_cnt_q < SW'(LOCK_WINS)) ? stable_cnt_q + SW'(1) : stable_cnt_q;
        have_hist_d  = 1'b1;
        last_best_d  = best;
        if (!i_mode) phase_d = best;
        case (state_q)
          ACQ:     if (stable_cnt_d >= SW'(LOCK_WINS)) state_d = TRACK;
          TRACK:   if (!same_best) state_d = ACQ;
          default: ;
        endcase
      end
    end

    if (i_enable) begin
      if (i_mode) phase_d = i_manual_phase;
      locked_d = i_mode || (state_d == TRACK);
    end

    if (i_restart) begin
      state_d       = ACQ;
      phase_cnt_d   = '0;
      sym_cnt_d     = '0;
      for (int p = 0; p < OS; p++) energy_d[p] = '0;
      have_hist_d   = 1'b0;
      last_best_d   = '0;
      stable_cnt_d  = '0;
      phase_d       = phase_q;
      locked_d      = 1'b0;
      bit_valid_d   = 1'b0;
      strobe_done_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q       <= IDLE;
      phase_cnt_q   <= '0;
      sym_cnt_q     <= '0;
      for (int p = 0; p < OS; p++) energy_q[p] <= '0;
      have_hist_q   <= 1'b0;
      last_best_q   <= '0;
      stable_cnt_q  <= '0;
      phase_q       <= '0;
      locked_q      <= 1'b0;
      bit_q         <= 1'b0;
      bit_valid_q   <= 1'b0;
      strobe_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_cnt_q   <= phase_cnt_d;
      sym_cnt_q     <= sym_cnt_d;
      for (int p = 0; p < OS; p++) energy_q[p] <= energy_d[p];
      have_hist_q   <= have_hist_d;
      last_best_q   <= last_best_d;
      stable_cnt_q  <= stable_cnt_d;
      phase_q       <= phase_d;
      locked_q      <= locked_d;
      bit_q         <= bit_d;
      bit_valid_q   <= bit_valid_d;
      strobe_done_q <= strobe_done_d;
    end
  end

  assign o_bit       = bit_q;
  assign o_bit_valid = bit_valid_q;
  assign o_phase     = phase_q;
  assign o_locked    = locked_q;

endmodule

// File: tb/tb_rx_phase_align.sv
// Scoreboarded bench for rx_phase_align: a reference model predicts each decided bit
// from the driven stream; phase and lock are checked at window boundaries.
module tb_rx_phase_align;

  localparam int NB  = 8;
  localparam int OS  = 4;
  localparam int WIN = 256;

  logic                 clock = 1'b0;
  logic                 i_reset, i_enable, i_valid, i_mode, i_restart;
  logic signed [NB-1:0] i_data;
  logic [1:0]           i_manual_phase;
  logic                 o_bit, o_bit_valid, o_locked;
  logic [1:0]           o_phase;

  int n_compared   = 0;
  int n_mismatched = 0;
  logic exp_q[$];

  int m_n, m_phase, m_manual;
  int m_e[OS];

  int pat_a[4]     = '{10, 100, 20, 5};
  int pat_shift[4] = '{10, 20, 5, 100};
  int pat_tie[4]   = '{50, -50, -50, -50};
  int pat_man[4]   = '{10, 100, -20, 5};
  int pat_big[4]   = '{127, 127, -128, 127};

  rx_phase_align #(.NB_DATA(NB), .OS(OS), .WIN_LOG2(6), .LOCK_WINS(2)) dut (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_data(i_data), .i_mode(i_mode), .i_manual_phase(i_manual_phase),
    .i_restart(i_restart), .o_bit(o_bit), .o_bit_valid(o_bit_valid),
    .o_phase(o_phase), .o_locked(o_locked)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Every strobe must match the oldest predicted bit.
  always @(negedge clock) begin
    if (o_bit_valid === 1'b1) begin
      if (exp_q.size() == 0) checkOutput("extra_strobe", 1, 0);
      else checkOutput("bit", {31'd0, o_bit}, {31'd0, exp_q.pop_front()});
    end
  end

  task automatic modelClear();
    m_n = 0;
    for (int p = 0; p < OS; p++) m_e[p] = 0;
  endtask

  task automatic modelSample(input logic signed [NB-1:0] data);
    int c, best;
    c = m_n % OS;
    if (c == m_phase) exp_q.push_back(data[NB-1]);
    m_e[c] += (data < 0) ? -int'(data) : int'(data);
    if (m_n % WIN == WIN - 1) begin
      best = 0;
      for (int p = 1; p < OS; p++) if (m_e[p] > m_e[best]) best = p;
      if (!m_manual) m_phase = best;
      for (int p = 0; p < OS; p++) m_e[p] = 0;
    end
    m_n++;
  endtask

  task automatic applyStimulus(input logic valid, input logic signed [NB-1:0] data);
    i_valid = valid;
    i_data  = data;
    if (valid && i_enable) modelSample(data);
    @(posedge clock);
    #1;
  endtask

  function automatic logic signed [NB-1:0] getSample(input int pid, input int k);
    int p, s, v;
    p = k % 4;
    s = k / 4;
    case (pid)
      0: v = pat_a[p];
      1: v = pat_shift[p];
      2: v = (p == 1 && (s % 2) == 1) ? -100 : pat_a[p];
      3: v = pat_tie[p];
      4: v = pat_man[p];
      5: v = -128;
      default: v = pat_big[p];
    endcase
    return NB'(v);
  endfunction

  task automatic runStream(input int pid, input int first, input int count);
    for (int k = first; k < first + count; k++) applyStimulus(1'b1, getSample(pid, k));
  endtask

  task automatic checkState(input string tag, input int exp_phase, input int exp_locked);
    checkOutput({tag, "_phase"}, {30'd0, o_phase}, exp_phase);
    checkOutput({tag, "_locked"}, {31'd0, o_locked}, exp_locked);
  endtask

  task automatic doReset();
    i_reset   = 1'b1;
    i_valid   = 1'b0;
    i_restart = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    i_reset = 1'b0;
    modelClear();
    m_phase = 0;
    checkOutput("rst_bit", {31'd0, o_bit}, 0);
    checkOutput("rst_valid", {31'd0, o_bit_valid}, 0);
    checkState("rst", 0, 0);
  endtask

  task automatic pulseRestart();
    i_restart = 1'b1;
    i_valid   = 1'b0;
    @(posedge clock);
    #1;
    i_restart = 1'b0;
    modelClear();
  endtask

  initial begin
    i_reset = 1'b1; i_enable = 1'b1; i_valid = 1'b0; i_data = '0;
    i_mode = 1'b0; i_manual_phase = 2'd0; i_restart = 1'b0;
    m_manual = 0;
    doReset();

    // Auto search locks onto the dominant phase 1.
    runStream(0, 0, 256);   checkState("a_w1", 1, 0);
    runStream(0, 256, 256); checkState("a_w2", 1, 1);

    // Peak moves to phase 3: lock drops, then relocks one window later.
    runStream(1, 512, 256); checkState("d_w3", 3, 0);
    runStream(1, 768, 256); checkState("d_w4", 3, 1);

    pulseRestart();
    checkState("restart", 3, 0);

    // Alternating sign on phase 1 after restart.
    runStream(2, 0, 256);   checkState("b_w1", 1, 0);
    runStream(2, 256, 256); checkState("b_w2", 1, 1);
    applyStimulus(1'b0, '0);

    doReset();
    runStream(3, 0, 256);   checkState("c_w1", 0, 0);
    runStream(3, 256, 256); checkState("c_w2", 0, 1);
    applyStimulus(1'b0, '0);

    doReset();
    i_mode = 1'b1; i_manual_phase = 2'd2;
    m_manual = 1; m_phase = 2;
    applyStimulus(1'b0, '0);
    checkState("m_set", 2, 1);
    runStream(4, 0, 512);   checkState("m_end", 2, 1);
    applyStimulus(1'b0, '0);
    i_mode = 1'b0; m_manual = 0;

    doReset();
    runStream(5, 0, 256);   checkState("e_w1", 0, 0);
    runStream(6, 256, 256); checkState("e_w2", 2, 0);

    // Disabled cycles must neither strobe nor advance the phase counter.
    i_enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, -8'sd1);
      checkOutput("en_valid", {31'd0, o_bit_valid}, 0);
    end
    i_enable = 1'b1;
    applyStimulus(1'b0, '0);
    checkState("en_hold", 2, 0);
    runStream(6, 512, 8);
    applyStimulus(1'b0, '0);
    applyStimulus(1'b0, '0);

    checkOutput("sb_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
